// File: rtl/tfacc_outbuf.sv
// tfacc_outbuf: collects byte-wide core result writes into 16-byte lines.
// Each line has per-byte strobes. Closed lines wait in a small FIFO, and
// each one is written out as a single-beat 128-bit AXI4 write.
module tfacc_outbuf #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  o_we,
  input  logic [31:0]           o_adr,
  input  logic [7:0]            o_d,
  output logic                  o_rdy,
  input  logic                  flush,
  output logic                  busy,
  output logic                  err,
  output logic [3:0]            M00_AXI_AWID,
  output logic [ADDR_WIDTH-1:0] M00_AXI_AWADDR,
  output logic [7:0]            M00_AXI_AWLEN,
  output logic [2:0]            M00_AXI_AWSIZE,
  output logic [1:0]            M00_AXI_AWBURST,
  output logic [3:0]            M00_AXI_AWCACHE,
  output logic [2:0]            M00_AXI_AWPROT,
  output logic                  M00_AXI_AWVALID,
  input  logic                  M00_AXI_AWREADY,
  output logic [127:0]          M00_AXI_WDATA,
  output logic [15:0]           M00_AXI_WSTRB,
  output logic                  M00_AXI_WLAST,
  output logic                  M00_AXI_WVALID,
  input  logic                  M00_AXI_WREADY,
  input  logic [1:0]            M00_AXI_BRESP,
  input  logic                  M00_AXI_BVALID,
  output logic                  M00_AXI_BREADY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} state_t;

  // Open (coalescing) line
  logic [27:0]  tag_q, tag_d;
  logic [127:0] data_q, data_d;
  logic [15:0]  strb_q, strb_d;
  logic         valid_q, valid_d;
  logic         flush_pend_q, flush_pend_d;

  // Closed-line FIFO storage and pointers
  logic [27:0]  mem_tag  [FIFO_DEPTH];
  logic [127:0] mem_data [FIFO_DEPTH];
  logic [15:0]  mem_strb [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  // Write channel FSM and output registers
  state_t                state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [127:0]          wdata_q;
  logic [15:0]           wstrb_q;

  logic fifo_full, fifo_empty, accept, tag_hit, flush_do, push, pop;

  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == '0);
  assign o_rdy      = !fifo_full;
  assign accept     = o_we && !fifo_full;
  assign tag_hit    = valid_q && (tag_q == o_adr[31:4]);
  // Flush only proceeds in a cycle with no write so it never races a merge.
  assign flush_do   = !o_we && !fifo_full && flush_pend_q;
  // Both close paths push the current open line as it stands.
  assign push       = (accept && valid_q && !tag_hit) || (flush_do && valid_q);

  // Open-line next state: merge, reopen on tag change, close on flush.
  always_comb begin
    tag_d        = tag_q;
    data_d       = data_q;
    strb_d       = strb_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    if (flush_do) begin
      valid_d      = 1'b0;
      flush_pend_d = 1'b0;
    end
    if (accept) begin
      if (tag_hit) begin
        data_d[{o_adr[3:0], 3'b000} +: 8] = o_d;
        strb_d[o_adr[3:0]]                = 1'b1;
      end else begin
        tag_d                             = o_adr[31:4];
        data_d                            = '0;
        data_d[{o_adr[3:0], 3'b000} +: 8] = o_d;
        strb_d                            = 16'h0001 << o_adr[3:0];
        valid_d                           = 1'b1;
      end
    end
    if (flush) flush_pend_d = 1'b1;
  end

  // Open-line state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q        <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // FIFO storage: plain RAM write port, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_tag[wr_ptr_q]  <= tag_q;
      mem_data[wr_ptr_q] <= data_q;
      mem_strb[wr_ptr_q] <= strb_q;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Write FSM next state: AW and W complete independently, then wait for B.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    err_d     = err_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_XFER;
        end
      end
      S_XFER: begin
        if (awvalid_q && M00_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M00_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (M00_AXI_BVALID) begin
          if (M00_AXI_BRESP != 2'b00) err_d = 1'b1;
          bready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, handshake flags and the registered read of the FIFO head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      err_q     <= err_d;
      if (pop) begin
        awaddr_q <= {{(ADDR_WIDTH-32){1'b0}}, mem_tag[rd_ptr_q], 4'h0};
        wdata_q  <= mem_data[rd_ptr_q];
        wstrb_q  <= mem_strb[rd_ptr_q];
      end
    end
  end

  assign busy            = valid_q || flush_pend_q || !fifo_empty || (state_q != S_IDLE);
  assign err             = err_q;
  assign M00_AXI_AWID    = 4'h0;
  assign M00_AXI_AWADDR  = awaddr_q;
  assign M00_AXI_AWLEN   = 8'h00;
  assign M00_AXI_AWSIZE  = 3'b100;
  assign M00_AXI_AWBURST = 2'b01;
  assign M00_AXI_AWCACHE = 4'b0011;
  assign M00_AXI_AWPROT  = 3'b000;
  assign M00_AXI_AWVALID = awvalid_q;
  assign M00_AXI_WDATA   = wdata_q;
  assign M00_AXI_WSTRB   = wstrb_q;
  assign M00_AXI_WLAST   = wvalid_q;
  assign M00_AXI_WVALID  = wvalid_q;
  assign M00_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_tfacc_outbuf.sv
// Testbench for tfacc_outbuf: a line-level reference model plus an AXI slave.
// A per-cycle monitor compares every AW and W beat against the expected-line queue.
module tb_tfacc_outbuf;

  logic         clk = 1'b0;
  logic         reset;
  logic         o_we, o_rdy, flush, busy, err;
  logic [31:0]  o_adr;
  logic [7:0]   o_d;
  logic [3:0]   awid, awcache;
  logic [39:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize, awprot;
  logic [1:0]   awburst, bresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;

  tfacc_outbuf #(.FIFO_DEPTH(4), .ADDR_WIDTH(40)) dut (
    .clk(clk), .reset(reset),
    .o_we(o_we), .o_adr(o_adr), .o_d(o_d), .o_rdy(o_rdy),
    .flush(flush), .busy(busy), .err(err),
    .M00_AXI_AWID(awid), .M00_AXI_AWADDR(awaddr), .M00_AXI_AWLEN(awlen),
    .M00_AXI_AWSIZE(awsize), .M00_AXI_AWBURST(awburst), .M00_AXI_AWCACHE(awcache),
    .M00_AXI_AWPROT(awprot), .M00_AXI_AWVALID(awvalid), .M00_AXI_AWREADY(awready),
    .M00_AXI_WDATA(wdata), .M00_AXI_WSTRB(wstrb), .M00_AXI_WLAST(wlast),
    .M00_AXI_WVALID(wvalid), .M00_AXI_WREADY(wready),
    .M00_AXI_BRESP(bresp), .M00_AXI_BVALID(bvalid), .M00_AXI_BREADY(bready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [39:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
  } line_t;

  // Reference model: the open line and the lines it has closed, in order.
  line_t        expq[$];
  logic [27:0]  m_tag;
  logic [127:0] m_data;
  logic [15:0]  m_strb;
  bit           m_valid;

  // Slave-side bookkeeping and the DUT values captured at each handshake.
  bit           aw_done, w_done, bad_next;
  int           nwrites = 0;
  logic [39:0]  last_addr;
  logic [127:0] last_data;
  logic [15:0]  last_strb;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] lane_mask(input logic [15:0] s);
    logic [127:0] m = '0;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction

  function automatic void model_clear();
    m_valid = 0; m_tag = '0; m_data = '0; m_strb = '0;
  endfunction

  function automatic void model_close();
    if (m_valid) expq.push_back('{addr: {8'h00, m_tag, 4'h0}, data: m_data, strb: m_strb});
    model_clear();
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [7:0] d);
    if (m_valid && m_tag != a[31:4]) model_close();
    if (!m_valid) begin
      m_valid = 1;
      m_tag   = a[31:4];
    end
    m_data[8*a[3:0] +: 8] = d;
    m_strb[a[3:0]]        = 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    int n = 0;
    o_we = 1'b1; o_adr = a; o_d = d;
    while (!o_rdy && n < 300) begin
      cyc(1);
      n++;
    end
    if (!o_rdy) chk("o_rdy_timeout", o_rdy, 1);
    @(posedge clk);
    #1;
    model_write(a, d);
    o_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    model_close();
    cyc(1);
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      cyc(1);
      n++;
    end
    chk("busy_low", busy, 0);
    chk("lines_outstanding", expq.size(), 0);
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (nwrites < target && n < 300) begin
      cyc(1);
      n++;
    end
    chk("write_count", nwrites, target);
  endtask

  // Monitor and AXI slave: checks outputs at negedge, updates slave state after the edge.
  initial begin
    bit aw_hold = 0, w_hold = 0, aw_fire, w_fire, b_fire;
    bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_done = 0; w_done = 0; aw_hold = 0; w_hold = 0; bvalid = 1'b0;
        continue;
      end
      chk("aw_constants", {awid, awlen, awsize, awburst, awcache, awprot},
          {4'h0, 8'h00, 3'b100, 2'b01, 4'b0011, 3'b000});
      chk("wlast_eq_wvalid", wlast, wvalid);
      if (aw_hold) chk("awvalid_held", awvalid, 1);
      if (w_hold)  chk("wvalid_held", wvalid, 1);
      if (aw_done) chk("awvalid_dropped", awvalid, 0);
      if (w_done)  chk("wvalid_dropped", wvalid, 0);
      if (awvalid || wvalid) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", awvalid | wvalid, 0);
        end else begin
          if (awvalid) chk("awaddr", awaddr, expq[0].addr);
          if (wvalid) begin
            chk("wstrb", wstrb, expq[0].strb);
            chk("wdata", wdata & lane_mask(expq[0].strb), expq[0].data & lane_mask(expq[0].strb));
          end
        end
      end
      if (bvalid) chk("bready", bready, 1);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready;
      aw_hold = awvalid && !awready;
      w_hold  = wvalid && !wready;
      if (aw_fire) last_addr = awaddr;
      if (w_fire) begin
        last_data = wdata;
        last_strb = wstrb;
      end
      @(posedge clk);
      #1;
      if (reset) continue;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      if (b_fire)  bvalid = 1'b0;
      if (aw_done && w_done) begin
        if (expq.size() > 0) void'(expq.pop_front());
        nwrites++;
        aw_done  = 0;
        w_done   = 0;
        bvalid   = 1'b1;
        bresp    = bad_next ? 2'b10 : 2'b00;
        bad_next = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    reset = 1'b0; o_we = 1'b0; o_adr = '0; o_d = '0; flush = 1'b0;
    awready = 1'b1; wready = 1'b1; bad_next = 0;
    model_clear();
    #1 reset = 1'b1;
    cyc(2);
    chk("rst_o_rdy", o_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_valids", {awvalid, wvalid, bready}, 3'b000);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    reset = 1'b0;
    cyc(2);

    // Full line of incrementing bytes
    for (int i = 0; i < 16; i++) wr(32'h1000 + i, 8'(i));
    do_flush();
    chk("busy_after_flush", busy, 1);
    wait_idle();
    chk("t1_count", nwrites, 1);
    chk("t1_addr", last_addr, 40'h1000);
    chk("t1_strb", last_strb, 16'hFFFF);
    chk("t1_data", last_data, 128'h0F0E0D0C0B0A09080706050403020100);

    // Tag change closes the line; flush closes the second
    wr(32'h2003, 8'hAA);
    wr(32'h2007, 8'hBB);
    wr(32'h2010, 8'hCC);
    wait_writes(2);
    chk("t2a_addr", last_addr, 40'h2000);
    chk("t2a_strb", last_strb, 16'h0088);
    chk("t2a_lanes", {last_data[63:56], last_data[31:24]}, 16'hBBAA);
    do_flush();
    wait_idle();
    chk("t2b_addr", last_addr, 40'h2010);
    chk("t2b_strb", last_strb, 16'h0001);
    chk("t2b_lane0", last_data[7:0], 8'hCC);

    // Repeat write to one lane, last value wins
    wr(32'h3005, 8'h11);
    wr(32'h3005, 8'h22);
    do_flush();
    wait_idle();
    chk("t3_count", nwrites, 4);
    chk("t3_strb", last_strb, 16'h0020);
    chk("t3_lane5", last_data[47:40], 8'h22);

    // Back-pressure: FIFO fills, o_rdy drops after the sixth write
    base = nwrites;
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t4_o_rdy_open", o_rdy, 1);
      wr(32'h8000 + 32'(16 * i), 8'(8'h40 + i));
    end
    chk("t4_o_rdy_full", o_rdy, 0);
    cyc(3);
    chk("t4_o_rdy_still_full", o_rdy, 0);
    awready = 1'b1; wready = 1'b1;
    wr(32'h8060, 8'h46);
    do_flush();
    wait_idle();
    chk("t4_count", nwrites, base + 7);
    chk("t4_last_addr", last_addr, 40'h8060);

    // AWREADY lags WREADY by three cycles
    awready = 1'b0; wready = 1'b1;
    wr(32'h7003, 8'h77);
    do_flush();
    n = 0;
    while (!(awvalid && !wvalid) && n < 50) begin
      cyc(1);
      n++;
    end
    chk("t5_w_first", {awvalid, wvalid}, 2'b10);
    cyc(3);
    chk("t5_aw_waiting", awvalid, 1);
    awready = 1'b1;
    wait_idle();
    chk("t5_addr", last_addr, 40'h7000);
    chk("t5_strb", last_strb, 16'h0008);

    // Error response is sticky
    bad_next = 1;
    wr(32'h4000, 8'h01);
    do_flush();
    wait_idle();
    chk("t6_err_set", err, 1);
    wr(32'h5000, 8'h02);
    do_flush();
    wait_idle();
    chk("t6_err_sticky", err, 1);

    // Reset during XFER abandons the transaction
    base = nwrites;
    awready = 1'b0; wready = 1'b0;
    wr(32'h6004, 8'h5A);
    do_flush();
    n = 0;
    while (!awvalid && n < 50) begin
      cyc(1);
      n++;
    end
    chk("t7_in_xfer", awvalid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t7_o_rdy", o_rdy, 1);
    chk("t7_busy", busy, 0);
    chk("t7_err", err, 0);
    chk("t7_valids", {awvalid, wvalid, bready}, 3'b000);
    chk("t7_awaddr", awaddr, 0);
    chk("t7_wdata", wdata, 0);
    chk("t7_wstrb", wstrb, 0);
    expq.delete();
    model_clear();
    cyc(2);
    reset = 1'b0;
    awready = 1'b1; wready = 1'b1;
    cyc(10);
    chk("t7_busy_after", busy, 0);
    chk("t7_no_replay", nwrites, base);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
